// File: rtl/sie_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sie_pkg
//  Description : Shared types and constants for the SIE token receive path.
//                Holds the token sequencer state encoding, the token PID
//                values, the CRC5 good-residual constant and the field widths
//                that define a token packet layout.
//  Revision    : 1.0  initial release
// ============================================================================
package sie_pkg;

    // Token sequencer states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        PID      = 3'd2,
        DATA     = 3'd3,
        WAIT_EOP = 3'd4,
        DONE     = 3'd5
    } token_rx_state_t;

    // Remainder left in the CRC5 checker after a token with a correct CRC
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    // PID[1:0] shared by every token-class PID
    localparam logic [1:0] TOKEN_TYPE    = 2'b01;

    // Token PIDs (low nibble; the high nibble is its complement on the wire)
    localparam logic [3:0] PID_IN        = 4'h9;
    localparam logic [3:0] PID_OUT       = 4'h1;
    localparam logic [3:0] PID_SETUP     = 4'hD;
    localparam logic [3:0] PID_SOF       = 4'h5;

    // Field lengths in unstuffed bit times
    localparam logic [5:0] SYNC_BITS     = 6'd8;
    localparam logic [5:0] PID_BITS      = 6'd8;
    localparam logic [5:0] DATA_BITS     = 6'd16;  // 11 payload + 5 CRC
    localparam logic [5:0] DATA_KEEP     = 6'd11;  // addr[6:0] + endp[3:0]

endpackage : sie_pkg
`default_nettype wire

// File: rtl/token_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : token_rx_ctrl
//  Description : Token-packet sequencer for the downstream SIE path. Follows
//                one received token bit by bit (SYNC, PID, 16 DATA bits, EOP),
//                frames the downstream CRC5 checker, captures PID / address /
//                endpoint and reports exactly one token_valid or token_err
//                pulse per packet.
//  Ports       :
//    clk              in   system clock
//    rst_n            in   synchronous active-low reset
//    en               in   bit strobe; all bit-level state advances on en=1
//    serial_in        in   decoded line bit, LSB first
//    is_stuffed       in   current bit is a stuffed bit (ignored)
//    pkt_start        in   first SYNC bit (with en)
//    eop_det          in   SE0 end-of-packet seen (with en)
//    crc5_ready       in   CRC5 checker has consumed its 16 data bits
//    crc5_reg[4:0]    in   CRC5 checker remainder
//    in_transmission  out  high in SYNC / PID / DATA
//    end_transmission out  high in DONE; checker clears on en
//    busy             out  state != IDLE
//    pid[3:0]         out  last good token PID
//    addr[6:0]        out  last good token address
//    endp[3:0]        out  last good token endpoint
//    token_valid      out  1-clk pulse, good token
//    token_err        out  1-clk pulse, bad or aborted packet
//  Revision    : 1.0  initial release
// ============================================================================
module token_rx_ctrl
    import sie_pkg::*;
#(
    parameter int EOP_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       serial_in,
    input  logic       is_stuffed,
    input  logic       pkt_start,
    input  logic       eop_det,
    input  logic       crc5_ready,
    input  logic [4:0] crc5_reg,
    output logic       in_transmission,
    output logic       end_transmission,
    output logic       busy,
    output logic [3:0] pid,
    output logic [6:0] addr,
    output logic [3:0] endp,
    output logic       token_valid,
    output logic       token_err
);

    localparam logic [5:0] c_EOP_TIMEOUT = 6'(EOP_TIMEOUT);

    token_rx_state_t r_state;
    token_rx_state_t w_state_nxt;

    logic [5:0]  r_bit_cnt;
    logic [7:0]  r_pid_sr;
    logic [10:0] r_data_sr;
    logic [3:0]  r_pid;
    logic [6:0]  r_addr;
    logic [3:0]  r_endp;
    logic        r_token_valid;
    logic        r_token_err;

    logic        w_bit_tick;    // a real (unstuffed) bit time
    logic [5:0]  w_cnt_inc;
    logic        w_check_pass;
    logic        w_done_ok;     // entering DONE with a good token
    logic        w_done_err;    // entering DONE with any failure

    assign w_bit_tick = en & ~is_stuffed;
    assign w_cnt_inc  = r_bit_cnt + 6'd1;

    assign w_check_pass = (r_pid_sr[7:4] == ~r_pid_sr[3:0])
                        && (r_pid_sr[1:0] == TOKEN_TYPE)
                        && crc5_ready
                        && (crc5_reg == CRC5_RESIDUAL);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and state-decoded outputs
    // eop_det wins over field completion, so an EOP that lands with the last
    // DATA bit still ends as a short packet.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_done_ok        = 1'b0;
        w_done_err       = 1'b0;
        in_transmission  = 1'b0;
        end_transmission = 1'b0;
        busy             = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (en && pkt_start) begin
                    w_state_nxt = SYNC;
                end
            end
            SYNC: begin
                in_transmission = 1'b1;
                if (en && eop_det) begin
                    w_state_nxt = DONE;
                    w_done_err  = 1'b1;
                end else if (w_bit_tick && (w_cnt_inc == SYNC_BITS)) begin
                    w_state_nxt = PID;
                end
            end
            PID: begin
                in_transmission = 1'b1;
                if (en && eop_det) begin
                    w_state_nxt = DONE;
                    w_done_err  = 1'b1;
                end else if (w_bit_tick && (w_cnt_inc == PID_BITS)) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                in_transmission = 1'b1;
                if (en && eop_det) begin
                    w_state_nxt = DONE;
                    w_done_err  = 1'b1;
                end else if (w_bit_tick && (w_cnt_inc == DATA_BITS)) begin
                    w_state_nxt = WAIT_EOP;
                end
            end
            WAIT_EOP: begin
                if (en && eop_det) begin
                    w_state_nxt = DONE;
                    w_done_ok   = w_check_pass;
                    w_done_err  = ~w_check_pass;
                end else if (w_bit_tick && (w_cnt_inc == c_EOP_TIMEOUT)) begin
                    w_state_nxt = DONE;
                    w_done_err  = 1'b1;
                end
            end
            DONE: begin
                end_transmission = 1'b1;
                if (en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit counter, shift registers, captured fields and result pulses.
    // Pulses are not gated by en: once launched they last exactly one clk.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt     <= 6'd0;
            r_pid_sr      <= 8'd0;
            r_data_sr     <= 11'd0;
            r_pid         <= 4'd0;
            r_addr        <= 7'd0;
            r_endp        <= 4'd0;
            r_token_valid <= 1'b0;
            r_token_err   <= 1'b0;
        end else begin
            r_token_valid <= w_done_ok;
            r_token_err   <= w_done_err;

            if (w_done_ok) begin
                r_pid  <= r_pid_sr[3:0];
                r_addr <= r_data_sr[6:0];
                r_endp <= r_data_sr[10:7];
            end

            // The pkt_start bit is itself the first SYNC bit, so SYNC is
            // entered with one bit already counted.
            if (w_state_nxt != r_state) begin
                r_bit_cnt <= ((r_state == IDLE) && w_bit_tick) ? 6'd1 : 6'd0;
            end else if (w_bit_tick && (r_state != IDLE) && (r_state != DONE)) begin
                r_bit_cnt <= w_cnt_inc;
            end

            if ((r_state == PID) && w_bit_tick) begin
                r_pid_sr <= {serial_in, r_pid_sr[7:1]};
            end

            // Only the 11 payload bits are kept; the trailing CRC bits belong
            // to the CRC5 checker.
            if ((r_state == DATA) && w_bit_tick && (r_bit_cnt < DATA_KEEP)) begin
                r_data_sr <= {serial_in, r_data_sr[10:1]};
            end
        end
    end

    assign pid         = r_pid;
    assign addr        = r_addr;
    assign endp        = r_endp;
    assign token_valid = r_token_valid;
    assign token_err   = r_token_err;

endmodule : token_rx_ctrl
`default_nettype wire

// File: tb/tb_token_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_token_rx_ctrl
//  Description : Directed self-checking bench for token_rx_ctrl. A small
//                behavioural CRC5 checker sits beside the DUT and is framed
//                by in_transmission / end_transmission exactly as the SIE
//                wires the real one.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_token_rx_ctrl;
    import sie_pkg::*;

    localparam int EOP_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       serial_in = 1'b0;
    logic       is_stuffed = 1'b0;
    logic       pkt_start = 1'b0;
    logic       eop_det = 1'b0;
    logic       crc5_ready;
    logic [4:0] crc5_reg;
    logic       in_transmission;
    logic       end_transmission;
    logic       busy;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       token_valid;
    logic       token_err;

    token_rx_ctrl #(.EOP_TIMEOUT(EOP_TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .serial_in        (serial_in),
        .is_stuffed       (is_stuffed),
        .pkt_start        (pkt_start),
        .eop_det          (eop_det),
        .crc5_ready       (crc5_ready),
        .crc5_reg         (crc5_reg),
        .in_transmission  (in_transmission),
        .end_transmission (end_transmission),
        .busy             (busy),
        .pid              (pid),
        .addr             (addr),
        .endp             (endp),
        .token_valid      (token_valid),
        .token_err        (token_err)
    );

    always #5 clk = ~clk;

    // ---------------- CRC5 helpers (x^5 + x^2 + 1, init all ones) ----------
    function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
        logic [4:0] r;
        r = {c[3:0], 1'b0};
        if (b ^ c[4]) r = r ^ 5'b00101;
        return r;
    endfunction

    function automatic logic [4:0] crc5_gen(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) c = crc_step(c, d[i]);
        return ~c;
    endfunction

    // ---------------- behavioural CRC5 checker -----------------------------
    // Counts unstuffed packet bits from the pkt_start bit; bits 16..31 are
    // the token DATA field.
    logic [5:0] m_cnt;
    logic [4:0] m_crc;
    logic       m_rdy;
    int         et_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt <= 6'd0;
            m_crc <= 5'h1F;
            m_rdy <= 1'b0;
        end else if (end_transmission && en) begin
            m_cnt  <= 6'd0;
            m_crc  <= 5'h1F;
            m_rdy  <= 1'b0;
            et_cnt <= et_cnt + 1;
        end else if (en && !is_stuffed && (in_transmission || (pkt_start && !busy))) begin
            m_cnt <= m_cnt + 6'd1;
            if (m_cnt >= 6'd16 && m_cnt < 6'd32) begin
                m_crc <= crc_step(m_crc, serial_in);
                if (m_cnt == 6'd31) m_rdy <= 1'b1;
            end
        end
    end

    assign crc5_reg   = m_crc;
    assign crc5_ready = m_rdy;

    // ---------------- pulse monitor ----------------------------------------
    int v_cnt = 0, e_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (token_valid) v_cnt <= v_cnt + 1;
        if (token_err) e_cnt <= e_cnt + 1;
        if (token_valid && token_err) both_cnt <= both_cnt + 1;
    end

    // ---------------- checking ---------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- stimulus ---------------------------------------------
    typedef struct packed {
        logic b;
        logic st;
        logic ps;
        logic eop;
    } tbit_t;

    tbit_t q[$];
    int    gap = 0;     // en-low cycles inserted before every bit

    task automatic drive_bit(input tbit_t x);
        repeat (gap) begin
            @(negedge clk);
            en = 1'b0; serial_in = 1'($urandom_range(0, 1));
            is_stuffed = 1'b0; pkt_start = 1'b0; eop_det = 1'b0;
        end
        @(negedge clk);
        en = 1'b1; serial_in = x.b; is_stuffed = x.st;
        pkt_start = x.ps; eop_det = x.eop;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit('{b: 1'b1, st: 1'b0, ps: 1'b0, eop: 1'b0});
    endtask

    // Builds SYNC, PID and the first nd of the 16 DATA bits. With stuff=1 a
    // stuffed 0 follows every run of six 1s inside the DATA field.
    task automatic build(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e,
                         input logic [4:0] flip, input bit stuff, input int nd);
        logic [4:0]  crc;
        logic [15:0] d;
        int          run;
        run = 0;
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back('{b: (i == 7), st: 1'b0, ps: (i == 0), eop: 1'b0});
        for (int i = 0; i < 8; i++) q.push_back('{b: p[i], st: 1'b0, ps: 1'b0, eop: 1'b0});
        crc = crc5_gen({e, a}) ^ flip;
        d = {crc[0], crc[1], crc[2], crc[3], crc[4], e, a};
        for (int i = 0; i < nd; i++) begin
            q.push_back('{b: d[i], st: 1'b0, ps: 1'b0, eop: 1'b0});
            if (stuff) begin
                run = d[i] ? run + 1 : 0;
                if (run == 6) begin
                    q.push_back('{b: 1'b0, st: 1'b1, ps: 1'b0, eop: 1'b0});
                    run = 0;
                end
            end
        end
    endtask

    task automatic play();
        foreach (q[i]) drive_bit(q[i]);
    endtask

    // eop_mode 0: EOP on the bit after the last one built; 1: EOP on the last bit
    task automatic run_pkt(input string tag, input logic [7:0] p, input logic [6:0] a,
                           input logic [3:0] e, input logic [4:0] flip, input bit stuff,
                           input int nd, input int eop_mode, input bit exp_ok,
                           input logic [3:0] ep, input logic [6:0] ea, input logic [3:0] ee);
        int    v0, e0, t0;
        tbit_t last;
        v0 = v_cnt; e0 = e_cnt; t0 = et_cnt;
        build(p, a, e, flip, stuff, nd);
        if (eop_mode == 1) begin
            last = q.pop_back();
            last.eop = 1'b1;
            q.push_back(last);
        end else begin
            q.push_back('{b: 1'b0, st: 1'b0, ps: 1'b0, eop: 1'b1});
        end
        play();
        idle_bits(2);
        chk({tag, "/valid_pulses"}, v_cnt - v0, exp_ok ? 1 : 0);
        chk({tag, "/err_pulses"},   e_cnt - e0, exp_ok ? 0 : 1);
        chk({tag, "/both"},         both_cnt, 0);
        chk({tag, "/end_tx_seen"},  et_cnt - t0, 1);
        chk({tag, "/busy"},         busy, 0);
        chk({tag, "/pid"},          pid, ep);
        chk({tag, "/addr"},         addr, ea);
        chk({tag, "/endp"},         endp, ee);
    endtask

    initial begin
        int v0, e0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst/busy", busy, 0);
        chk("rst/in_tx", in_transmission, 0);
        chk("rst/end_tx", end_transmission, 0);
        chk("rst/fields", {pid, addr, endp}, 0);
        chk("rst/pulses", {token_valid, token_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- tests 1-3, back-to-back en and en 1-in-4 ----
        for (int g = 0; g < 2; g++) begin
            gap = (g == 0) ? 0 : 3;
            run_pkt($sformatf("t1_in_g%0d", gap),   8'h69, 7'h15, 4'h3, 5'b00000, 0, 16, 0,
                    1, 4'h9, 7'h15, 4'h3);
            run_pkt($sformatf("t2_crc_g%0d", gap),  8'h69, 7'h15, 4'h3, 5'b00100, 0, 16, 0,
                    0, 4'h9, 7'h15, 4'h3);
            run_pkt($sformatf("t3_pid_g%0d", gap),  8'h68, 7'h15, 4'h3, 5'b00000, 0, 16, 0,
                    0, 4'h9, 7'h15, 4'h3);
            run_pkt($sformatf("t3_sof_g%0d", gap),  8'hA5, 7'h2A, 4'h6, 5'b00000, 0, 16, 0,
                    1, 4'h5, 7'h2A, 4'h6);
        end
        gap = 0;

        // ---- test 4: stuffed bits in addr/endp, then the plain stream ----
        run_pkt("t4_stuffed", 8'hE1, 7'h7F, 4'hF, 5'b00000, 1, 16, 0, 1, 4'h1, 7'h7F, 4'hF);
        run_pkt("t3_reload",  8'hA5, 7'h2A, 4'h6, 5'b00000, 0, 16, 0, 1, 4'h5, 7'h2A, 4'h6);
        run_pkt("t4_plain",   8'hE1, 7'h7F, 4'hF, 5'b00000, 0, 16, 0, 1, 4'h1, 7'h7F, 4'hF);

        // ---- test 5: short packets and EOP timeout ----
        run_pkt("t5_short4",  8'h2D, 7'h11, 4'h2, 5'b00000, 0, 4, 0, 0, 4'h1, 7'h7F, 4'hF);
        run_pkt("t5_eop_last", 8'h2D, 7'h11, 4'h2, 5'b00000, 0, 16, 1, 0, 4'h1, 7'h7F, 4'hF);
        run_pkt("t5_short_pid", 8'h2D, 7'h11, 4'h2, 5'b00000, 0, 0, 0, 0, 4'h1, 7'h7F, 4'hF);

        v0 = v_cnt; e0 = e_cnt;
        build(8'h2D, 7'h11, 4'h2, 5'b00000, 0, 16);
        play();
        idle_bits(EOP_TIMEOUT - 1);
        chk("t5_to/busy_before", busy, 1);
        chk("t5_to/no_err_early", e_cnt - e0, 0);
        idle_bits(1);
        chk("t5_to/err_pulse", token_err, 1);
        chk("t5_to/end_tx", end_transmission, 1);
        chk("t5_to/busy_done", busy, 1);
        idle_bits(1);
        chk("t5_to/busy_drop", busy, 0);
        chk("t5_to/err_count", e_cnt - e0, 1);
        chk("t5_to/valid_count", v_cnt - v0, 0);
        chk("t5_to/fields", {pid, addr, endp}, {4'h1, 7'h7F, 4'hF});

        // ---- test 6: reset during DATA ----
        v0 = v_cnt; e0 = e_cnt;
        build(8'h69, 7'h15, 4'h3, 5'b00000, 0, 6);
        play();
        chk("t6/in_tx_mid", in_transmission, 1);
        @(negedge clk);
        en = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6/busy", busy, 0);
        chk("t6/in_tx", in_transmission, 0);
        chk("t6/fields", {pid, addr, endp}, 0);
        chk("t6/pulses_now", {token_valid, token_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6/no_pulse", (v_cnt - v0) + (e_cnt - e0), 0);
        run_pkt("t6_after", 8'h69, 7'h15, 4'h3, 5'b00000, 0, 16, 0, 1, 4'h9, 7'h15, 4'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_token_rx_ctrl
`default_nettype wire
